// File: rtl/gpc_pkg.sv
// Shared constants and state encoding for the 1,3,5->4 GPC preimage generator.
package gpc_pkg;
  localparam int W0_DEF      = 5;
  localparam int W1_DEF      = 3;
  localparam int W2_DEF      = 1;
  localparam int SW_DEF      = 4;
  localparam int WT0         = 1;
  localparam int WT1         = 2;
  localparam int WT2         = 4;
  localparam int GPC_MAX_SUM = 15;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
endpackage

// File: rtl/gpc135_sum_ref.sv
// Combinational weighted popcount of a (src0, src1, src2) GPC input pattern.
module gpc135_sum_ref
  import gpc_pkg::*;
#(
  parameter int W0 = W0_DEF,
  parameter int W1 = W1_DEF,
  parameter int W2 = W2_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [W0-1:0] src0,
  input  logic [W1-1:0] src1,
  input  logic [W2-1:0] src2,
  output logic [SW-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < W0; i++) sum = sum + (src0[i] ? SW'(WT0) : '0);
    for (int i = 0; i < W1; i++) sum = sum + (src1[i] ? SW'(WT1) : '0);
    for (int i = 0; i < W2; i++) sum = sum + (src2[i] ? SW'(WT2) : '0);
  end
endmodule

// File: rtl/gpc135_4_preimage_gen.sv
// Streams every (src0, src1, src2) pattern whose weighted bit count equals the
// requested target, in ascending candidate order, over a valid/ready port.
module gpc135_4_preimage_gen
  import gpc_pkg::*;
#(
  parameter int W0 = W0_DEF,
  parameter int W1 = W1_DEF,
  parameter int W2 = W2_DEF,
  parameter int SW = SW_DEF,
  parameter int CW = W0 + W1 + W2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SW-1:0] req_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W0-1:0] src0,
  output logic [W1-1:0] src1,
  output logic [W2-1:0] src2,
  output logic          done,
  output logic [CW:0]   match_count
);
  localparam int MW = CW + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cand;
  logic [SW-1:0] tgt;
  logic [SW-1:0] cand_sum;
  logic          free, eval, hit, last, accept;

  gpc135_sum_ref #(.W0(W0), .W1(W1), .W2(W2), .SW(SW)) u_sum (
    .src0 (cand[W0-1:0]),
    .src1 (cand[W0+W1-1:W0]),
    .src2 (cand[CW-1:W0+W1]),
    .sum  (cand_sum)
  );

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE);
    free      = !out_valid || out_ready;
    accept    = req_ready && req_valid;
    eval      = (state == SCAN) && free;
    hit       = eval && (cand_sum == tgt);
    last      = (cand == '1);
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (eval && last) state_nxt = FLUSH;
      FLUSH:   if (free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      tgt         <= '0;
      out_valid   <= 1'b0;
      src0        <= '0;
      src1        <= '0;
      src2        <= '0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        tgt         <= req_target;
        cand        <= '0;
        match_count <= '0;
      end
      // Output register only moves when free, so a stalled beat holds and the
      // counter waits with it: nothing is skipped or repeated.
      if (eval) begin
        cand <= cand + CW'(1);
        if (hit) begin
          src0        <= cand[W0-1:0];
          src1        <= cand[W0+W1-1:W0];
          src2        <= cand[CW-1:W0+W1];
          out_valid   <= 1'b1;
          match_count <= match_count + MW'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (state == FLUSH && free) begin
        done      <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gpc135_4_preimage_gen.sv
// Directed-plus-random bench for gpc135_4_preimage_gen against an arithmetic
// enumeration model of the weighted-sum preimage set.
module tb_gpc135_4_preimage_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [3:0] req_target;
  logic       out_valid, out_ready;
  logic [4:0] src0;
  logic [2:0] src1;
  logic [0:0] src2;
  logic       done;
  logic [9:0] match_count;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got[$];

  gpc135_4_preimage_gen dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .out_valid(out_valid), .out_ready(out_ready),
    .src0(src0), .src1(src1), .src2(src2), .done(done), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: weight-1 bits are k[4:0], weight-2 bits k[7:5], weight-4 bit k[8].
  function automatic int wsum(input int k);
    logic [8:0] v;
    v = k[8:0];
    return $countones(v[4:0]) + 2 * $countones(v[7:5]) + 4 * int'(v[8]);
  endfunction

  task automatic run_req(input int tgt, input int rdy_pct, input bit chk_time);
    int n;
    bit fin;
    logic hold;
    logic [8:0] held, pat;
    exp_q.delete();
    got.delete();
    for (int k = 0; k < 512; k++) if (wsum(k) == tgt) exp_q.push_back(k[8:0]);
    @(negedge clk);
    req_target = 4'(tgt);
    req_valid  = 1'b1;
    out_ready  = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    n = 0; fin = 0; hold = 0; held = '0;
    while (!fin && n < 4000) begin
      @(negedge clk);
      req_valid  = 1'b0;
      req_target = 4'($urandom);
      out_ready  = (int'($urandom_range(99)) < rdy_pct);
      pat = {src2, src1, src0};
      if (n == 1) check("busy_ready", 32'(req_ready), 32'd0);
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(pat), 32'(held));
      end
      if (out_valid && out_ready) got.push_back(pat);
      hold = out_valid && !out_ready;
      held = pat;
      if (done) begin
        fin = 1;
        if (chk_time) check("done_cycle", 32'(n), 32'd513);
      end
      n++;
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("beat_count", 32'(got.size()), 32'(exp_q.size()));
    check("match_count", 32'(match_count), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check("beat_pattern", 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    bit seen [512];
    int total, dups, nseen, beats, n;
    rst = 1'b1; req_valid = 1'b0; req_target = '0; out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mc", 32'(match_count), 32'd0);
    check("rst_src", 32'({src2, src1, src0}), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_req(0, 100, 1);
    check("t0_beat", 32'(got.size() > 0 ? got[0] : 9'h1ff), 32'h000);
    run_req(15, 100, 1);
    check("t15_beat", 32'(got.size() > 0 ? got[0] : 9'h000), 32'h1ff);
    run_req(2, 100, 1);
    check("t2_count", 32'(got.size()), 32'd13);
    check("t2_first", 32'(got.size() > 0 ? got[0] : 9'h1ff), 32'h003);
    run_req(14, 50, 0);
    check("t14_count", 32'(got.size()), 32'd5);

    total = 0; dups = 0; nseen = 0;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    for (int t = 0; t < 16; t++) begin
      run_req(t, 70, 0);
      total += got.size();
      foreach (got[i]) begin
        if (seen[got[i]]) dups++;
        seen[got[i]] = 1'b1;
      end
    end
    for (int i = 0; i < 512; i++) if (seen[i]) nseen++;
    check("total_beats", 32'(total), 32'd512);
    check("dup_beats", 32'(dups), 32'd0);
    check("all_seen", 32'(nseen), 32'd512);

    // Abort a scan with reset after three beats, then rerun the same target.
    @(negedge clk);
    req_target = 4'd5; req_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    beats = 0; n = 0;
    while (beats < 3 && n < 600) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (out_valid) beats++;
      n++;
    end
    if (beats < 3) check("rst_timeout", 32'd0, 32'd1);
    check("mc_before_rst", 32'(match_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_mc", 32'(match_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    run_req(5, 60, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
